// File: rtl/spi_slave_core.sv
// SPI slave core running entirely in the system clock domain.
// CS_N, SCK and MOSI are synchronised and SCK edges are detected on the
// synchronised copy. Receive and transmit each use a shift register. A
// single holding buffer feeds the TX shift register through a ready/load
// handshake.
//
// state  | meaning
// IDLE   | deselected, MISO held low, SCK ignored
// LOAD   | one clk after CS_N fall: holding buffer -> TX shift register
// ACTIVE | selected, sampling/shifting on SCK edges until CS_N rises
module spi_slave_core #(
    parameter int                DATA_W      = 16,
    parameter int                CPOL        = 1,
    parameter int                CPHA        = 1,
    parameter int                MSB_FIRST   = 1,
    parameter int                SYNC_STAGES = 2,
    parameter logic [DATA_W-1:0] IDLE_TX     = '0
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              CS_N,
    input  logic              SCK,
    input  logic              MOSI,
    output logic              MISO,
    output logic              MISO_OE,
    output logic [DATA_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic              rx_ack,
    output logic              rx_overrun,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_load,
    output logic              tx_ready,
    output logic              tx_underrun,
    output logic              frame_abort,
    output logic              busy
);

    localparam int              CNT_W    = $clog2(DATA_W + 1);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(DATA_W - 1);
    localparam logic            SCK_IDLE = (CPOL != 0);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_LOAD,
        ST_ACTIVE
    } state_t;

    // Synchroniser chains. The CS_N chain resets to "selected" so that a pin
    // already low when reset is released never looks like a fresh CS_N fall;
    // a frame interrupted by reset is therefore ignored until CS_N rises.
    logic [SYNC_STAGES-1:0] cs_sync_q, cs_sync_d;
    logic [SYNC_STAGES-1:0] sck_sync_q, sck_sync_d;
    logic [SYNC_STAGES-1:0] mosi_sync_q, mosi_sync_d;
    logic                   cs_prev_q, cs_prev_d;
    logic                   sck_prev_q, sck_prev_d;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [DATA_W-1:0]   rx_shift_q, rx_shift_d;
    logic [DATA_W-1:0]   rx_data_q, rx_data_d;
    logic                rx_valid_q, rx_valid_d;
    logic                rx_overrun_q, rx_overrun_d;
    logic                rx_pend_q, rx_pend_d;
    logic [DATA_W-1:0]   tx_buf_q, tx_buf_d;
    logic                tx_full_q, tx_full_d;
    logic [DATA_W-1:0]   tx_shift_q, tx_shift_d;
    logic                tx_underrun_q, tx_underrun_d;
    logic                frame_abort_q, frame_abort_d;
    logic                busy_q, busy_d;
    logic                miso_q, miso_d;
    logic                next_load_q, next_load_d;

    logic              cs_s, sck_s, mosi_s;
    logic              cs_fall, cs_rise, sck_rise, sck_fall;
    logic              lead_edge, trail_edge, sample_edge, shift_edge;
    logic              consume;
    logic [DATA_W-1:0] word_sel;
    logic [DATA_W-1:0] rx_next;

    function automatic logic tx_head(input logic [DATA_W-1:0] w);
        return (MSB_FIRST != 0) ? w[DATA_W-1] : w[0];
    endfunction

    function automatic logic [DATA_W-1:0] tx_advance(input logic [DATA_W-1:0] w);
        return (MSB_FIRST != 0) ? {w[DATA_W-2:0], 1'b0} : {1'b0, w[DATA_W-1:1]};
    endfunction

    function automatic logic [DATA_W-1:0] rx_insert(input logic [DATA_W-1:0] w,
                                                    input logic b);
        return (MSB_FIRST != 0) ? {w[DATA_W-2:0], b} : {b, w[DATA_W-1:1]};
    endfunction

    // Pin synchronisation and edge detection on the synchronised copies.
    always_comb begin
        cs_sync_d   = {cs_sync_q[SYNC_STAGES-2:0], CS_N};
        sck_sync_d  = {sck_sync_q[SYNC_STAGES-2:0], SCK};
        mosi_sync_d = {mosi_sync_q[SYNC_STAGES-2:0], MOSI};
        cs_s        = cs_sync_q[SYNC_STAGES-1];
        sck_s       = sck_sync_q[SYNC_STAGES-1];
        mosi_s      = mosi_sync_q[SYNC_STAGES-1];
        cs_prev_d   = cs_s;
        sck_prev_d  = sck_s;
        cs_fall     = cs_prev_q & ~cs_s;
        cs_rise     = ~cs_prev_q & cs_s;
        sck_rise    = sck_s & ~sck_prev_q;
        sck_fall    = ~sck_s & sck_prev_q;
        lead_edge   = (CPOL != 0) ? sck_fall : sck_rise;
        trail_edge  = (CPOL != 0) ? sck_rise : sck_fall;
        sample_edge = (CPHA != 0) ? trail_edge : lead_edge;
        shift_edge  = (CPHA != 0) ? lead_edge : trail_edge;
    end

    // Frame sequencing, shift registers, TX handshake and status pulses.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        rx_shift_d    = rx_shift_q;
        rx_data_d     = rx_data_q;
        rx_valid_d    = 1'b0;
        rx_overrun_d  = 1'b0;
        tx_buf_d      = tx_buf_q;
        tx_full_d     = tx_full_q;
        tx_shift_d    = tx_shift_q;
        tx_underrun_d = 1'b0;
        frame_abort_d = 1'b0;
        busy_d        = busy_q;
        miso_d        = miso_q;
        next_load_d   = next_load_q;
        consume       = 1'b0;
        word_sel      = tx_full_q ? tx_buf_q : IDLE_TX;
        rx_next       = rx_insert(rx_shift_q, mosi_s);

        case (state_q)
            ST_IDLE: begin
                miso_d      = 1'b0;
                cnt_d       = '0;
                next_load_d = 1'b0;
                if (cs_fall) begin
                    state_d = ST_LOAD;
                    busy_d  = 1'b1;
                end
            end
            ST_LOAD: begin
                consume = 1'b1;
                if (CPHA == 0) begin
                    miso_d     = tx_head(word_sel);
                    tx_shift_d = tx_advance(word_sel);
                end else begin
                    tx_shift_d = word_sel;
                end
                if (cs_rise) begin
                    state_d = ST_IDLE;
                    busy_d  = 1'b0;
                    miso_d  = 1'b0;
                end else begin
                    state_d = ST_ACTIVE;
                end
            end
            ST_ACTIVE: begin
                if (cs_rise) begin
                    state_d       = ST_IDLE;
                    busy_d        = 1'b0;
                    miso_d        = 1'b0;
                    cnt_d         = '0;
                    next_load_d   = 1'b0;
                    frame_abort_d = (cnt_q != '0);
                end else begin
                    if (sample_edge) begin
                        rx_shift_d = rx_next;
                        if (cnt_q == LAST_CNT) begin
                            cnt_d        = '0;
                            rx_data_d    = rx_next;
                            rx_valid_d   = 1'b1;
                            rx_overrun_d = rx_pend_q;
                            // CPHA=0: the trailing edge right after this sample
                            // already carries the first bit of the next word.
                            if (CPHA == 0) begin
                                consume    = 1'b1;
                                tx_shift_d = word_sel;
                            end else begin
                                next_load_d = 1'b1;
                            end
                        end else begin
                            cnt_d = cnt_q + CNT_W'(1);
                        end
                    end
                    if (shift_edge) begin
                        if (next_load_q) begin
                            consume     = 1'b1;
                            next_load_d = 1'b0;
                            miso_d      = tx_head(word_sel);
                            tx_shift_d  = tx_advance(word_sel);
                        end else begin
                            miso_d     = tx_head(tx_shift_q);
                            tx_shift_d = tx_advance(tx_shift_q);
                        end
                    end
                end
            end
            default: begin
                state_d = ST_IDLE;
                busy_d  = 1'b0;
                miso_d  = 1'b0;
            end
        endcase

        // A word-start load empties the buffer before a same-clk tx_load refills it.
        if (consume) begin
            tx_underrun_d = ~tx_full_q;
            tx_full_d     = 1'b0;
        end
        if (tx_load && !tx_full_d) begin
            tx_buf_d  = tx_data;
            tx_full_d = 1'b1;
        end

        // An ack arriving with the rx_valid pulse belongs to the older word.
        if (rx_valid_q) begin
            rx_pend_d = 1'b1;
        end else if (rx_ack) begin
            rx_pend_d = 1'b0;
        end else begin
            rx_pend_d = rx_pend_q;
        end
    end

    // All state registers with asynchronous active-low reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cs_sync_q     <= '0;
            sck_sync_q    <= {SYNC_STAGES{SCK_IDLE}};
            mosi_sync_q   <= '0;
            cs_prev_q     <= 1'b0;
            sck_prev_q    <= SCK_IDLE;
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            rx_shift_q    <= '0;
            rx_data_q     <= '0;
            rx_valid_q    <= 1'b0;
            rx_overrun_q  <= 1'b0;
            rx_pend_q     <= 1'b0;
            tx_buf_q      <= '0;
            tx_full_q     <= 1'b0;
            tx_shift_q    <= '0;
            tx_underrun_q <= 1'b0;
            frame_abort_q <= 1'b0;
            busy_q        <= 1'b0;
            miso_q        <= 1'b0;
            next_load_q   <= 1'b0;
        end else begin
            cs_sync_q     <= cs_sync_d;
            sck_sync_q    <= sck_sync_d;
            mosi_sync_q   <= mosi_sync_d;
            cs_prev_q     <= cs_prev_d;
            sck_prev_q    <= sck_prev_d;
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rx_shift_q    <= rx_shift_d;
            rx_data_q     <= rx_data_d;
            rx_valid_q    <= rx_valid_d;
            rx_overrun_q  <= rx_overrun_d;
            rx_pend_q     <= rx_pend_d;
            tx_buf_q      <= tx_buf_d;
            tx_full_q     <= tx_full_d;
            tx_shift_q    <= tx_shift_d;
            tx_underrun_q <= tx_underrun_d;
            frame_abort_q <= frame_abort_d;
            busy_q        <= busy_d;
            miso_q        <= miso_d;
            next_load_q   <= next_load_d;
        end
    end

    assign MISO        = miso_q;
    assign MISO_OE     = busy_q;
    assign busy        = busy_q;
    assign rx_data     = rx_data_q;
    assign rx_valid    = rx_valid_q;
    assign rx_overrun  = rx_overrun_q;
    assign tx_ready    = ~tx_full_q;
    assign tx_underrun = tx_underrun_q;
    assign frame_abort = frame_abort_q;

endmodule

// File: tb/tb_spi_slave_core.sv
// Bench for spi_slave_core: instance A is mode 3 / 16-bit / MSB first,
// instance B is mode 0 / 8-bit / LSB first. Both share clock and reset.
module tb_spi_slave_core;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    // Instance A signals
    logic        a_csn = 1'b1, a_sck = 1'b1, a_mosi = 1'b0;
    logic        a_miso, a_miso_oe, a_rx_valid, a_rx_overrun;
    logic [15:0] a_rx_data;
    logic        a_rx_ack = 1'b0;
    logic [15:0] a_tx_data = '0;
    logic        a_tx_load = 1'b0;
    logic        a_tx_ready, a_tx_underrun, a_frame_abort, a_busy;

    // Instance B signals
    logic        b_csn = 1'b1, b_sck = 1'b0, b_mosi = 1'b0;
    logic        b_miso, b_miso_oe, b_rx_valid, b_rx_overrun;
    logic [7:0]  b_rx_data;
    logic        b_rx_ack = 1'b0;
    logic [7:0]  b_tx_data = '0;
    logic        b_tx_load = 1'b0;
    logic        b_tx_ready, b_tx_underrun, b_frame_abort, b_busy;

    spi_slave_core #(.DATA_W(16), .CPOL(1), .CPHA(1), .MSB_FIRST(1),
                     .SYNC_STAGES(2), .IDLE_TX(16'h0000)) dut_a (
        .clk(clk), .rst_n(rst_n), .CS_N(a_csn), .SCK(a_sck), .MOSI(a_mosi),
        .MISO(a_miso), .MISO_OE(a_miso_oe), .rx_data(a_rx_data),
        .rx_valid(a_rx_valid), .rx_ack(a_rx_ack), .rx_overrun(a_rx_overrun),
        .tx_data(a_tx_data), .tx_load(a_tx_load), .tx_ready(a_tx_ready),
        .tx_underrun(a_tx_underrun), .frame_abort(a_frame_abort), .busy(a_busy));

    spi_slave_core #(.DATA_W(8), .CPOL(0), .CPHA(0), .MSB_FIRST(0),
                     .SYNC_STAGES(2), .IDLE_TX(8'h00)) dut_b (
        .clk(clk), .rst_n(rst_n), .CS_N(b_csn), .SCK(b_sck), .MOSI(b_mosi),
        .MISO(b_miso), .MISO_OE(b_miso_oe), .rx_data(b_rx_data),
        .rx_valid(b_rx_valid), .rx_ack(b_rx_ack), .rx_overrun(b_rx_overrun),
        .tx_data(b_tx_data), .tx_load(b_tx_load), .tx_ready(b_tx_ready),
        .tx_underrun(b_tx_underrun), .frame_abort(b_frame_abort), .busy(b_busy));

    int n_checks = 0;
    int n_errors = 0;

    // Pulse counters and received-word history, sampled on the falling clock edge.
    int          a_valid_n = 0, a_ovr_n = 0, a_und_n = 0, a_abt_n = 0;
    int          b_valid_n = 0, b_abt_n = 0;
    logic [15:0] a_last_rx = '0, a_prev_rx = '0;
    logic [7:0]  b_last_rx = '0, b_prev_rx = '0;

    always @(negedge clk) begin
        if (a_rx_valid) begin
            a_valid_n++;
            a_prev_rx = a_last_rx;
            a_last_rx = a_rx_data;
        end
        if (a_rx_overrun)  a_ovr_n++;
        if (a_tx_underrun) a_und_n++;
        if (a_frame_abort) a_abt_n++;
        if (b_rx_valid) begin
            b_valid_n++;
            b_prev_rx = b_last_rx;
            b_last_rx = b_rx_data;
        end
        if (b_frame_abort) b_abt_n++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic clks(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Mode 3 master: change MOSI on the falling edge, sample MISO on the rising edge.
    task automatic a_bits(input logic [15:0] m, input int nbits, output logic [15:0] s);
        s = '0;
        for (int i = 0; i < nbits; i++) begin
            a_sck  = 1'b0;
            a_mosi = m[15-i];
            clks(8);
            a_sck    = 1'b1;
            s[15-i]  = a_miso;
            clks(8);
        end
    endtask

    // Mode 0 master, LSB first: MOSI set before the rising edge, MISO sampled on it.
    task automatic b_word(input logic [7:0] m, output logic [7:0] s);
        s = '0;
        for (int i = 0; i < 8; i++) begin
            b_mosi = m[i];
            clks(8);
            b_sck = 1'b1;
            s[i]  = b_miso;
            clks(8);
            b_sck = 1'b0;
        end
    endtask

    task automatic a_load(input logic [15:0] d);
        a_tx_data = d;
        a_tx_load = 1'b1;
        clks(1);
        a_tx_load = 1'b0;
    endtask

    task automatic a_ack();
        a_rx_ack = 1'b1;
        clks(1);
        a_rx_ack = 1'b0;
    endtask

    typedef struct packed {
        logic [15:0] tx;
        logic [15:0] mosi;
        logic [15:0] exp_rx;
        logic [15:0] exp_miso;
    } vec_t;

    vec_t vecs[4];

    initial begin
        logic [15:0] s1, s2;
        logic [7:0]  t1, t2;
        int          v0, u0, o0, ab0, bv0, bab0;

        vecs[0] = '{tx: 16'hA5C3, mosi: 16'h1234, exp_rx: 16'h1234, exp_miso: 16'hA5C3};
        vecs[1] = '{tx: 16'h0F0F, mosi: 16'hFFFF, exp_rx: 16'hFFFF, exp_miso: 16'h0F0F};
        vecs[2] = '{tx: 16'h8001, mosi: 16'h0000, exp_rx: 16'h0000, exp_miso: 16'h8001};
        vecs[3] = '{tx: 16'hFFFF, mosi: 16'h8001, exp_rx: 16'h8001, exp_miso: 16'hFFFF};

        clks(4);
        check("reset tx_ready", a_tx_ready, 1);
        check("reset busy", a_busy, 0);
        check("reset miso", a_miso, 0);
        check("reset miso_oe", a_miso_oe, 0);
        check("reset rx_data", a_rx_data, 0);
        check("reset rx_valid", a_rx_valid, 0);
        rst_n = 1'b1;
        clks(10);

        // Table: single-word mode 3 frames with a preloaded TX word.
        o0 = a_ovr_n;
        for (int v = 0; v < 4; v++) begin
            a_load(vecs[v].tx);
            check("tx_ready low after load", a_tx_ready, 0);
            v0 = a_valid_n;
            u0 = a_und_n;
            a_csn = 1'b0;
            clks(8);
            check("tx_ready after LOAD", a_tx_ready, 1);
            check("busy in frame", a_busy, 1);
            check("miso_oe in frame", a_miso_oe, 1);
            a_bits(vecs[v].mosi, 16, s1);
            clks(8);
            a_csn = 1'b1;
            clks(8);
            check("table rx_data", a_rx_data, vecs[v].exp_rx);
            check("table miso word", s1, vecs[v].exp_miso);
            check("table rx_valid count", a_valid_n - v0, 1);
            check("table no underrun", a_und_n - u0, 0);
            check("busy after frame", a_busy, 0);
            a_ack();
            clks(4);
        end
        check("no overrun when acked", a_ovr_n - o0, 0);

        // Mode 0, LSB first, two words under one CS_N.
        bv0 = b_valid_n;
        bab0 = b_abt_n;
        b_tx_data = 8'hC3;
        b_tx_load = 1'b1;
        clks(1);
        b_tx_load = 1'b0;
        b_csn = 1'b0;
        clks(8);
        check("mode0 first bit before SCK", b_miso, 1);
        check("mode0 miso_oe", b_miso_oe, 1);
        check("mode0 tx_ready after LOAD", b_tx_ready, 1);
        b_tx_data = 8'h5A;
        b_tx_load = 1'b1;
        clks(1);
        b_tx_load = 1'b0;
        b_word(8'h81, t1);
        b_word(8'h7E, t2);
        clks(8);
        b_csn = 1'b1;
        clks(8);
        check("mode0 rx_valid count", b_valid_n - bv0, 2);
        check("mode0 first rx", b_prev_rx, 8'h81);
        check("mode0 second rx", b_last_rx, 8'h7E);
        check("mode0 miso word1", t1, 8'hC3);
        check("mode0 miso word2", t2, 8'h5A);
        check("mode0 no abort", b_abt_n - bab0, 0);

        // Empty TX buffer and no ack across two words: underrun per word, overrun on word 2.
        v0 = a_valid_n; u0 = a_und_n; o0 = a_ovr_n;
        a_csn = 1'b0;
        clks(8);
        a_bits(16'h1111, 16, s1);
        a_bits(16'h2222, 16, s2);
        clks(8);
        a_csn = 1'b1;
        clks(8);
        check("underrun miso word1", s1, 16'h0000);
        check("underrun miso word2", s2, 16'h0000);
        check("underrun count", a_und_n - u0, 2);
        check("two-word rx_valid count", a_valid_n - v0, 2);
        check("overrun count", a_ovr_n - o0, 1);
        check("overrun rx_data is word2", a_rx_data, 16'h2222);
        check("overrun first word seen", a_prev_rx, 16'h1111);
        a_ack();
        clks(4);

        // Abort after 5 of 16 bits, then a clean frame.
        v0 = a_valid_n; ab0 = a_abt_n;
        a_load(16'h1357);
        a_csn = 1'b0;
        clks(8);
        a_bits(16'hF800, 5, s1);
        clks(8);
        a_csn = 1'b1;
        clks(8);
        check("abort pulse", a_abt_n - ab0, 1);
        check("abort no rx_valid", a_valid_n - v0, 0);
        check("abort partial miso", s1[15:11], 5'b00010);
        a_load(16'h2468);
        a_csn = 1'b0;
        clks(8);
        a_bits(16'hCAFE, 16, s1);
        clks(8);
        a_csn = 1'b1;
        clks(8);
        check("post-abort rx_data", a_rx_data, 16'hCAFE);
        check("post-abort miso", s1, 16'h2468);
        check("post-abort rx_valid", a_valid_n - v0, 1);
        check("post-abort no new abort", a_abt_n - ab0, 1);
        a_ack();
        clks(4);

        // Reset mid-word; remainder of the frame must be ignored.
        a_load(16'h0F0F);
        a_csn = 1'b0;
        clks(8);
        a_bits(16'hFFFF, 6, s1);
        rst_n = 1'b0;
        clks(2);
        check("midreset miso", a_miso, 0);
        check("midreset miso_oe", a_miso_oe, 0);
        check("midreset busy", a_busy, 0);
        check("midreset tx_ready", a_tx_ready, 1);
        check("midreset rx_data", a_rx_data, 0);
        check("midreset rx_valid", a_rx_valid, 0);
        check("midreset B rx_data", b_rx_data, 0);
        rst_n = 1'b1;
        clks(4);
        v0 = a_valid_n; ab0 = a_abt_n;
        a_bits(16'hFFFF, 10, s1);
        clks(8);
        a_csn = 1'b1;
        clks(8);
        check("ignored tail no rx_valid", a_valid_n - v0, 0);
        check("ignored tail no abort", a_abt_n - ab0, 0);
        check("ignored tail busy", a_busy, 0);
        a_load(16'h5AA5);
        a_csn = 1'b0;
        clks(8);
        a_bits(16'hBEEF, 16, s1);
        clks(8);
        a_csn = 1'b1;
        clks(8);
        check("post-reset rx_data", a_rx_data, 16'hBEEF);
        check("post-reset miso", s1, 16'h5AA5);
        check("post-reset rx_valid", a_valid_n - v0, 1);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/spi_slave_core.md
Name: spi_slave_core

Overview:
- Parameterised SPI slave; all logic runs in the system clock domain.
- Width, SPI mode (CPOL/CPHA) and bit order are parameters.
- Back-to-back words under one CS_N assertion; TX holding buffer with ready/load handshake; RX valid pulse, overrun, underrun and frame-abort flags.
- Sits between an MCU SPI master (CUBEMX-configured) and FPGA register/datapath logic; replaces fixed 16-bit mode-3 slaves.

Parameters:
DATA_W, 16, word width in bits (4..32)
CPOL, 1, SCK idle level
CPHA, 1, 0 = sample on leading edge, 1 = sample on trailing edge
MSB_FIRST, 1, 1 = MSB first on both MOSI and MISO
SYNC_STAGES, 2, synchroniser depth for CS_N/SCK/MOSI (2..3)
IDLE_TX, 0, word shifted out when TX buffer empty (DATA_W bits)

Ports:
clk  in  1  system clock; must be >= 8x SCK frequency
rst_n  in  1  asynchronous active-low reset
CS_N  in  1  chip select, active low, asynchronous pin
SCK  in  1  SPI clock pin
MOSI  in  1  master-out data pin
MISO  out  1  slave-out data
MISO_OE  out  1  1 while selected (pad tristate control)
rx_data  out  DATA_W  last complete received word
rx_valid  out  1  one-clk pulse: rx_data updated
rx_ack  in  1  consumer has taken rx_data
rx_overrun  out  1  one-clk pulse: word completed while previous word unacked
tx_data  in  DATA_W  word to send
tx_load  in  1  write tx_data into holding buffer when tx_ready=1
tx_ready  out  1  holding buffer empty
tx_underrun  out  1  one-clk pulse: word start with empty buffer
frame_abort  out  1  one-clk pulse: CS_N rose with 0 < bit count < DATA_W
busy  out  1  CS_N (synchronised) low

Behaviour:
- Reset: all flags/pulses 0, rx_data=0, MISO=0, MISO_OE=0, busy=0, tx_ready=1, bit count 0, state IDLE.
- Synchronisation: CS_N, SCK, MOSI pass through SYNC_STAGES flops. Edges are detected on synchronised SCK.
  - Leading edge = rising if CPOL=0, falling if CPOL=1.
  - Sample edge = leading if CPHA=0, trailing if CPHA=1.
  - Shift edge = the other edge.
- FSM states: IDLE, LOAD, ACTIVE.
  - IDLE -> LOAD on synchronised CS_N fall.
  - LOAD (1 clk) -> ACTIVE: moves holding buffer into TX shift register and sets tx_ready=1. If the buffer is empty, loads IDLE_TX and pulses tx_underrun.
  - ACTIVE -> IDLE on synchronised CS_N rise, from any bit count.
- MISO drive:
  - CPHA=0: first bit on MISO at exit from LOAD; each following bit on a shift edge.
  - CPHA=1: every bit, including the first, is driven on a shift edge.
  - MISO_OE=busy. MISO=0 in IDLE.
- Receive:
  - Each sample edge shifts the synchronised MOSI into the RX shift register (MSB- or LSB-first per MSB_FIRST) and increments the bit count.
  - On count==DATA_W: rx_data <= shift register, rx_valid pulses on the same clk, count wraps to 0.
  - Next-word TX load happens as in LOAD, on the first shift edge after wrap (CPHA=1) or immediately at wrap (CPHA=0).
- RX pending: set on rx_valid, cleared on rx_ack. rx_ack and rx_valid in the same clk leave pending set (new word).
  - On a word completion while pending is set: rx_overrun pulses; rx_data is still overwritten.
- TX handshake: tx_load while tx_ready=1 captures tx_data and drops tx_ready. tx_load while tx_ready=0 is ignored.
  - tx_load in the same clk as a word-start load: the buffer is consumed first (or underrun fires), then the new word is captured.
- Abort: CS_N rise with 0 < count < DATA_W pulses frame_abort, discards the partial word (no rx_valid), resets count, and leaves the holding buffer untouched.
- Latency: rx_valid occurs SYNC_STAGES+1 clk after the final sample edge at the pin. MISO changes SYNC_STAGES+1 clk after a shift edge at the pin.
- Asynchronous reset mid-frame returns all state to reset values. The block resumes only after the next CS_N fall; the remainder of the interrupted frame is ignored.

Test Plan:
- Mode 3, DATA_W=16: preload tx 0xA5C3, master sends 0x1234 -> rx_data=0x1234, one rx_valid, MISO bits read 0xA5C3, tx_ready re-asserts after LOAD.
- Mode 0 (CPOL=0, CPHA=0), DATA_W=8, LSB_FIRST: master sends 0x81 then 0x7E under one CS_N -> two rx_valid (0x81, 0x7E); first MISO bit valid before the first rising SCK.
- No tx_load before frame -> MISO shifts IDLE_TX=0x0000, tx_underrun pulses once per word.
- Two words with no rx_ack -> second rx_valid plus rx_overrun; rx_data = second word.
- CS_N rises after 5 of 16 bits -> frame_abort pulse, no rx_valid; next full frame received correctly.
- rst_n asserted mid-word -> all outputs return to reset values; the next frame 0xBEEF is received correctly.
